rx_dma_writer: RTL and testbench

- Multi-channel successor to the single-PHY receive path.
- Drains NCH PHY receive FIFOs with round-robin arbitration at frame granularity.
- Packs frame bytes into 16-bit master-FIFO words, framed as fixed-size DMA write bursts (3-word header + payload), with ring-buffer address management.
- Unlike the previous receiver, it honours master-FIFO backpressure, pads short bursts, splits long frames across bursts, and gates on DMA enable only at frame boundaries.

---
 rtl/rx_dma_writer.sv | 185 ++++++++++++++++++
 tb/tb_rx_dma_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_dma_writer.sv
// rx_dma_writer: round-robin drain of NCH PHY receive FIFOs into fixed-size DMA write bursts
// (3 header words + BURST_BYTES/2 payload words) with ring-buffer address management.
module rx_dma_writer #(
    parameter int NCH         = 2,
    parameter int BURST_BYTES = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [NCH*18-1:0] phy_dout,
    input  logic [NCH-1:0]    phy_empty,
    output logic [NCH-1:0]    phy_rd_en,
    output logic [17:0]       mst_din,
    output logic              mst_wr_en,
    input  logic              mst_full,
    input  logic              dma_en,
    input  logic [29:0]       dma_addr_start,
    input  logic [29:0]       dma_addr_end,
    output logic [29:0]       dma_addr_cur,
    output logic [31:0]       frame_cnt,
    output logic [3:0]        cur_ch
);
    localparam int BURST_DW = BURST_BYTES / 4;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [9:0] BB = 10'(BURST_BYTES);
    localparam logic [2:0] IDLE = 3'd0, PEEK = 3'd1, HDR0 = 3'd2, HDR1 = 3'd3,
                           HDR2 = 3'd4, DATA = 3'd5, PAD = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cur_ch_q, cur_ch_d, rr_q, rr_d, gnt, rr_nxt;
    logic [7:0]  hi_q, hi_d;
    logic        odd_q, odd_d, rd_pend_q, rd_pend_d, wr_q, wr_d, found, done;
    logic [9:0]  cnt_q, cnt_d, pc;
    logic [29:0] addr_q, addr_d, nxt, adv;
    logic [31:0] frame_q, frame_d;
    logic [17:0] din_q, din_d, word;
    logic [4:0]  idx;
    logic [NCH-1:0] rd;
    logic        unused_bits;

    assign word        = phy_dout[int'(cur_ch_q) * 18 +: 18];
    assign unused_bits = ^word[17:9];
    assign nxt         = addr_q + 30'(BURST_DW);
    // a burst never straddles the ring end
    assign adv    = ({1'b0, nxt} + 31'(BURST_DW) > {1'b0, dma_addr_end}) ? dma_addr_start : nxt;
    assign rr_nxt = (cur_ch_q == 4'(NCH - 1)) ? 4'd0 : cur_ch_q + 4'd1;
    assign pc     = odd_q ? cnt_q + 10'd1 : cnt_q + 10'd2;

    // descending scan so the lowest offset from the rr pointer wins
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = 5'(rr_q) + 5'(i);
            idx = (idx >= 5'(NCH)) ? idx - 5'(NCH) : idx;
            if (!phy_empty[idx[CW-1:0]]) begin
                found = 1'b1;
                gnt   = idx[3:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        rr_d     = rr_q;
        hi_d     = hi_q;
        odd_d    = odd_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        frame_d  = frame_q;
        din_d    = din_q;
        wr_d     = 1'b0;
        done     = 1'b0;
        rd       = '0;
        case (state_q)
            IDLE: if (dma_en && found && !mst_full) begin
                rd[gnt[CW-1:0]] = 1'b1;
                cur_ch_d        = gnt;
                state_d         = PEEK;
            end
            PEEK: if (word[8]) begin
                hi_d    = word[7:0];
                odd_d   = 1'b1;
                cnt_d   = 10'd1;
                state_d = HDR0;
                if (addr_q < dma_addr_start || addr_q >= dma_addr_end) addr_d = dma_addr_start;
            end else begin
                state_d = IDLE;
            end
            HDR0: if (!mst_full) begin
                wr_d    = 1'b1;
                din_d   = {2'b10, 4'h9, cur_ch_q, 8'(BURST_DW)};
                state_d = HDR1;
            end
            HDR1: if (!mst_full) begin
                wr_d    = 1'b1;
                din_d   = {2'b00, addr_q[29:14]};
                state_d = HDR2;
            end
            HDR2: if (!mst_full) begin
                wr_d    = 1'b1;
                din_d   = {2'b00, addr_q[13:0], 2'b00};
                state_d = DATA;
            end
            // one read in flight at a time so the end-of-frame word is never over-read
            DATA: if (rd_pend_q) begin
                if (!word[8]) begin
                    state_d = PAD;
                end else if (cnt_q == BB) begin
                    hi_d    = word[7:0];
                    odd_d   = 1'b1;
                    cnt_d   = 10'd1;
                    state_d = HDR0;
                end else if (odd_q) begin
                    wr_d   = 1'b1;
                    din_d  = {(cnt_q + 10'd1 == BB) ? 2'b01 : 2'b00, hi_q, word[7:0]};
                    odd_d  = 1'b0;
                    cnt_d  = cnt_q + 10'd1;
                    addr_d = (cnt_q + 10'd1 == BB) ? adv : addr_q;
                end else begin
                    hi_d  = word[7:0];
                    odd_d = 1'b1;
                    cnt_d = cnt_q + 10'd1;
                end
            end else if (!phy_empty[cur_ch_q[CW-1:0]] && !mst_full) begin
                rd[cur_ch_q[CW-1:0]] = 1'b1;
            end
            PAD: if (cnt_q == BB) begin
                done = 1'b1;
            end else if (!mst_full) begin
                wr_d  = 1'b1;
                din_d = {(pc == BB) ? 2'b01 : 2'b00, odd_q ? hi_q : 8'h00, 8'h00};
                odd_d = 1'b0;
                cnt_d = pc;
                if (pc == BB) begin
                    addr_d = adv;
                    done   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            frame_d = frame_q + 32'd1;
            rr_d    = rr_nxt;
            state_d = IDLE;
        end
    end

    assign rd_pend_d    = |rd;
    assign phy_rd_en    = sys_rst_n ? rd : '0;
    assign mst_din      = din_q;
    assign mst_wr_en    = wr_q;
    assign dma_addr_cur = addr_q;
    assign frame_cnt    = frame_q;
    assign cur_ch       = cur_ch_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cur_ch_q  <= '0;
            rr_q      <= '0;
            hi_q      <= '0;
            odd_q     <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            frame_q   <= '0;
            din_q     <= '0;
            wr_q      <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            rr_q      <= rr_d;
            hi_q      <= hi_d;
            odd_q     <= odd_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            frame_q   <= frame_d;
            din_q     <= din_d;
            wr_q      <= wr_d;
            rd_pend_q <= rd_pend_d;
        end
    end
endmodule

// File: tb/tb_rx_dma_writer.sv
// tb_rx_dma_writer: directed scenarios against a reference burst model for rx_dma_writer.
module tb_rx_dma_writer;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [35:0] phy_dout = '0;
    logic [1:0]  phy_empty = 2'b11;
    logic [1:0]  phy_rd_en;
    logic [17:0] mst_din;
    logic        mst_wr_en;
    logic        mst_full = 1'b0;
    logic        dma_en = 1'b0;
    logic [29:0] dma_addr_start = 30'h100;
    logic [29:0] dma_addr_end = 30'h200;
    logic [29:0] dma_addr_cur;
    logic [31:0] frame_cnt;
    logic [3:0]  cur_ch;

    int checks = 0;
    int failures = 0;
    int rdn = 0;
    int viol = 0;
    int snap, snap_rd;
    logic [8:0]  q0[$], q1[$];
    logic [17:0] cap[$], exp_q[$];
    logic [1:0]  took = '0;
    logic [29:0] ea = '0;

    rx_dma_writer #(.NCH(2), .BURST_BYTES(32)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .phy_dout(phy_dout), .phy_empty(phy_empty),
        .phy_rd_en(phy_rd_en), .mst_din(mst_din), .mst_wr_en(mst_wr_en), .mst_full(mst_full),
        .dma_en(dma_en), .dma_addr_start(dma_addr_start), .dma_addr_end(dma_addr_end),
        .dma_addr_cur(dma_addr_cur), .frame_cnt(frame_cnt), .cur_ch(cur_ch)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        took = phy_rd_en;
        if (mst_wr_en) cap.push_back(mst_din);
        if (phy_rd_en != 2'b00) rdn = rdn + 1;
        if ((mst_full && phy_rd_en != 2'b00) || !$onehot0(phy_rd_en) || (phy_rd_en & phy_empty) != 2'b00)
            viol = viol + 1;
    end

    // FIFO model: registered output, word valid the cycle after the strobe
    always @(negedge sys_clk) begin
        if (took[0] && q0.size() > 0) phy_dout[8:0] = q0.pop_front();
        if (took[1] && q1.size() > 0) phy_dout[26:18] = q1.pop_front();
        phy_empty = {q1.size() == 0, q0.size() == 0};
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [17:0] capw(input int i);
        return (i < cap.size()) ? cap[i] : 18'hx;
    endfunction

    task automatic do_reset();
        sys_rst_n = 1'b0;
        dma_en = 1'b0;
        mst_full = 1'b0;
        q0.delete();
        q1.delete();
        tick(3);
        cap.delete();
        exp_q.delete();
        ea = '0;
        rdn = 0;
        sys_rst_n = 1'b1;
        tick(1);
    endtask

    task automatic send(input int c, input int n, input logic [7:0] first);
        for (int k = 0; k < n; k++) begin
            if (c == 0) q0.push_back({1'b1, first + 8'(k)});
            else q1.push_back({1'b1, first + 8'(k)});
        end
        if (c == 0) q0.push_back(9'h000);
        else q1.push_back(9'h000);
    endtask

    task automatic model(input int c, input int n, input logic [7:0] first);
        int p;
        logic [7:0] b0, b1;
        if (ea < dma_addr_start || ea >= dma_addr_end) ea = dma_addr_start;
        for (int j = 0; j < (n + 31) / 32; j++) begin
            exp_q.push_back({2'b10, 4'h9, 4'(c), 8'h08});
            exp_q.push_back({2'b00, ea[29:14]});
            exp_q.push_back({2'b00, ea[13:0], 2'b00});
            for (int w = 0; w < 16; w++) begin
                p = j * 32 + 2 * w;
                b0 = (p < n) ? first + 8'(p) : 8'h00;
                b1 = (p + 1 < n) ? first + 8'(p + 1) : 8'h00;
                exp_q.push_back({(w == 15) ? 2'b01 : 2'b00, b0, b1});
            end
            ea = ea + 30'd8;
            if (ea + 30'd8 > dma_addr_end) ea = dma_addr_start;
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        int t = 0;
        while (frame_cnt < 32'(n) && t < 3000) begin
            tick(1);
            t++;
        end
        tick(5);
        chk({tag, "_frames"}, 64'(frame_cnt), 64'(n));
    endtask

    task automatic wait_cap(input int n, input string tag);
        int t = 0;
        while (cap.size() < n && t < 2000) begin
            tick(1);
            t++;
        end
        chk({tag, "_reach"}, 64'(cap.size() >= n), 64'd1);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, 64'(cap.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(capw(i)), 64'(exp_q[i]));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 64'(phy_rd_en), 64'd0);
        chk({tag, "_wr_en"}, 64'(mst_wr_en), 64'd0);
        chk({tag, "_din"}, 64'(mst_din), 64'd0);
        chk({tag, "_addr"}, 64'(dma_addr_cur), 64'd0);
        chk({tag, "_frames"}, 64'(frame_cnt), 64'd0);
        chk({tag, "_cur_ch"}, 64'(cur_ch), 64'd0);
    endtask

    initial begin
        tick(3);
        chk_reset_outputs("reset");

        do_reset();
        send(0, 10, 8'h01);
        model(0, 10, 8'h01);
        dma_en = 1'b1;
        wait_frames(1, "single");
        cmp_stream("single");
        chk("single_hdr0", 64'(capw(0)), 64'h29008);
        chk("single_hdr1", 64'(capw(1)), 64'h00000);
        chk("single_hdr2", 64'(capw(2)), 64'h00400);
        chk("single_first", 64'(capw(3)), 64'h00102);
        chk("single_fifth", 64'(capw(7)), 64'h0090A);
        chk("single_pad", 64'(capw(8)), 64'h00000);
        chk("single_last", 64'(capw(18)), 64'h10000);
        chk("single_addr", 64'(dma_addr_cur), 64'h108);

        do_reset();
        send(1, 40, 8'h11);
        model(1, 40, 8'h11);
        dma_en = 1'b1;
        wait_frames(1, "split");
        cmp_stream("split");
        chk("split_hdr0b", 64'(capw(19)), 64'h29108);
        chk("split_hdr2b", 64'(capw(21)), 64'h00420);
        chk("split_b2w0", 64'(capw(22)), 64'h03132);
        chk("split_b2w3", 64'(capw(25)), 64'h03738);
        chk("split_b2pad", 64'(capw(26)), 64'h00000);
        chk("split_cur_ch", 64'(cur_ch), 64'd1);
        chk("split_addr", 64'(dma_addr_cur), 64'h110);

        do_reset();
        send(0, 5, 8'h20);
        send(1, 3, 8'h40);
        send(0, 6, 8'h28);
        send(1, 4, 8'h48);
        send(0, 7, 8'h30);
        send(1, 2, 8'h50);
        model(0, 5, 8'h20);
        model(1, 3, 8'h40);
        model(0, 6, 8'h28);
        model(1, 4, 8'h48);
        model(0, 7, 8'h30);
        model(1, 2, 8'h50);
        tick(2);
        dma_en = 1'b1;
        wait_frames(6, "arb");
        cmp_stream("arb");
        for (int k = 0; k < 6; k++)
            chk($sformatf("arb_order%0d", k), 64'(capw(19 * k) & 18'h00F00), 64'((k % 2) << 8));

        do_reset();
        dma_addr_end = 30'h110;
        send(0, 4, 8'h60);
        send(1, 32, 8'h70);
        send(0, 9, 8'h90);
        model(0, 4, 8'h60);
        model(1, 32, 8'h70);
        model(0, 9, 8'h90);
        dma_en = 1'b1;
        wait_frames(3, "ring");
        cmp_stream("ring");
        chk("ring_a0", 64'(capw(2)), 64'h00400);
        chk("ring_a1", 64'(capw(21)), 64'h00420);
        chk("ring_a2", 64'(capw(40)), 64'h00400);
        chk("ring_exact_last", 64'(capw(37)), 64'h18E8F);
        chk("ring_addr", 64'(dma_addr_cur), 64'h108);
        dma_addr_end = 30'h200;

        do_reset();
        send(0, 24, 8'hA0);
        model(0, 24, 8'hA0);
        dma_en = 1'b1;
        wait_cap(6, "bp");
        mst_full = 1'b1;
        snap_rd = rdn;
        tick(1);
        snap = cap.size();
        tick(19);
        chk("bp_extra_writes", 64'(cap.size() - snap > 1), 64'd0);
        chk("bp_reads", 64'(rdn - snap_rd), 64'd0);
        mst_full = 1'b0;
        wait_frames(1, "bp");
        cmp_stream("bp");

        do_reset();
        send(0, 40, 8'h01);
        tick(20);
        chk("gate_no_read", 64'(rdn), 64'd0);
        model(0, 40, 8'h01);
        dma_en = 1'b1;
        wait_cap(4, "gate");
        dma_en = 1'b0;
        send(1, 5, 8'hC0);
        wait_frames(1, "gate");
        tick(20);
        cmp_stream("gate");
        chk("gate_ch1_untouched", 64'(q1.size()), 64'd6);
        chk("gate_frames_hold", 64'(frame_cnt), 64'd1);

        do_reset();
        send(0, 20, 8'h01);
        dma_en = 1'b1;
        wait_cap(5, "rst");
        sys_rst_n = 1'b0;
        tick(1);
        chk_reset_outputs("rst_mid");
        dma_en = 1'b0;
        snap = cap.size();
        sys_rst_n = 1'b1;
        tick(10);
        chk("rst_no_writes", 64'(cap.size()), 64'(snap));

        chk("protocol", 64'(viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
